mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter_pkg.sv | 11 +
 rtl/mem_bus_arbiter_rr.sv | 19 +
 rtl/mem_bus_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared FSM encoding and requester indices
package mem_bus_arbiter_pkg;
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_RESP   = 2'd2;

  localparam logic REQ_M0 = 1'b0;
  localparam logic REQ_M1 = 1'b1;
endpackage

// File: rtl/mem_bus_arbiter_rr.sv
// rtl/mem_bus_arbiter_rr.sv - two-input round-robin selector, combinational
module rr_arbiter2
  import mem_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // on a tie, favour whoever was not served last
      2'b11:   grant = (last == REQ_M1) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master arbiter onto one memory-controller port
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  input  logic        m0_we,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  input  logic        m1_we,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);
  state_t      state;
  logic        owner;
  logic        last;
  logic [7:0]  count;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        we_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [1:0]  grant;

  rr_arbiter2 u_rr (
    .req   ({m1_req, m0_req}),
    .last  (last),
    .grant (grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      owner   <= REQ_M0;
      last    <= REQ_M1;
      count   <= 8'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      we_q    <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant != 2'b00) begin
            owner   <= grant[1];
            addr_q  <= grant[1] ? m1_addr  : m0_addr;
            wdata_q <= grant[1] ? m1_wdata : m0_wdata;
            wstrb_q <= grant[1] ? m1_wstrb : m0_wstrb;
            we_q    <= grant[1] ? m1_we    : m0_we;
            count   <= 8'd0;
            state   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // mem_ready wins over a timeout landing on the same edge
          if (mem_ready) begin
            rdata_q <= we_q ? 32'd0 : mem_rdata;
            err_q   <= 1'b0;
            state   <= ST_RESP;
          end else if (count == 8'(TIMEOUT - 1)) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b1;
            state   <= ST_RESP;
          end else begin
            count <= count + 8'd1;
          end
        end
        ST_RESP: begin
          last  <= owner;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic in_access;
  logic in_resp;
  logic first_cycle;
  assign in_access   = (state == ST_ACCESS);
  assign in_resp     = (state == ST_RESP);
  assign first_cycle = in_access && (count == 8'd0);

  assign m0_gnt    = first_cycle && (owner == REQ_M0);
  assign m1_gnt    = first_cycle && (owner == REQ_M1);
  assign m0_rvalid = in_resp && (owner == REQ_M0);
  assign m1_rvalid = in_resp && (owner == REQ_M1);
  assign m0_err    = m0_rvalid && err_q;
  assign m1_err    = m1_rvalid && err_q;
  assign m0_rdata  = m0_rvalid ? rdata_q : 32'd0;
  assign m1_rdata  = m1_rvalid ? rdata_q : 32'd0;

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign mem_we    = in_access && we_q;
  assign mem_re    = in_access && !we_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed scoreboard bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
  logic        m0_we = 1'b0, m1_we = 1'b0;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_we, mem_re;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  typedef struct {
    logic        owner;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  mem_bus_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_we(m0_we),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_we(m1_we),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic owner, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.owner = owner;
    e.rdata = rdata;
    e.err   = err;
    sb.push_back(e);
  endtask

  // response side of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("idle_rdata0", m0_rvalid ? 32'd0 : m0_rdata, 32'd0);
      check("idle_rdata1", m1_rvalid ? 32'd0 : m1_rdata, 32'd0);
      if (m0_rvalid || m1_rvalid) begin
        if (sb.size() == 0) begin
          check("unexpected_rvalid", {31'd0, m1_rvalid}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("resp_owner", {31'd0, m1_rvalid}, {31'd0, e.owner});
          check("resp_single", {31'd0, m0_rvalid & m1_rvalid}, 32'd0);
          check("resp_rdata", e.owner ? m1_rdata : m0_rdata, e.rdata);
          check("resp_err", {31'd0, e.owner ? m1_err : m0_err}, {31'd0, e.err});
        end
      end
    end
  end

  initial begin
    int  re_cnt;
    bit  seen;

    // reset state
    #2;
    check("rst_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
    check("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    check("rst_mem_we_re", {30'd0, mem_we, mem_re}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    step();
    @(negedge clk) rst = 1'b0;

    // single read, m0
    m0_addr = 32'h10; m0_we = 1'b0; m0_req = 1'b1;
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    push(1'b0, 32'h1234_5678, 1'b0);
    step();
    check("rd_m0_gnt", {31'd0, m0_gnt}, 32'd1);
    check("rd_m1_gnt", {31'd0, m1_gnt}, 32'd0);
    check("rd_mem_re", {31'd0, mem_re}, 32'd1);
    check("rd_mem_we", {31'd0, mem_we}, 32'd0);
    check("rd_mem_addr", mem_addr, 32'h10);
    m0_req = 1'b0;
    step();
    check("rd_rvalid", {31'd0, m0_rvalid}, 32'd1);
    check("rd_gnt_gone", {31'd0, m0_gnt}, 32'd0);
    check("rd_re_gone", {31'd0, mem_re}, 32'd0);
    step();
    check("rd_idle", {30'd0, m0_rvalid, mem_re}, 32'd0);

    // both requesters held: strict alternation from m0 after reset
    rst = 1'b1; step(); @(negedge clk) rst = 1'b0;
    m0_addr = 32'h100; m1_addr = 32'h200; m1_we = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic own;
      own = i[0];
      step();
      check("alt_gnt", {30'd0, m1_gnt, m0_gnt}, own ? 32'd2 : 32'd1);
      check("alt_addr", mem_addr, own ? 32'h200 : 32'h100);
      mem_rdata = 32'h1000 + i;
      push(own, 32'h1000 + i, 1'b0);
      step();
      check("alt_rvalid", {30'd0, m1_rvalid, m0_rvalid}, own ? 32'd2 : 32'd1);
      if (i == 3) begin
        m0_req = 1'b0; m1_req = 1'b0;
      end
      step();
      check("alt_idle", {29'd0, m1_gnt, m0_gnt, mem_re}, 32'd0);
    end

    // m1 write with strobes; read data must not leak into a write response
    m1_addr = 32'h20; m1_wdata = 32'hAABB_CCDD; m1_wstrb = 4'b0101; m1_we = 1'b1;
    mem_rdata = 32'hDEAD_BEEF; m1_req = 1'b1;
    push(1'b1, 32'd0, 1'b0);
    step();
    check("wr_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd2);
    check("wr_we_re", {30'd0, mem_we, mem_re}, 32'd2);
    check("wr_wstrb", {28'd0, mem_wstrb}, 32'h5);
    check("wr_wdata", mem_wdata, 32'hAABB_CCDD);
    check("wr_addr", mem_addr, 32'h20);
    m1_req = 1'b0;
    step();
    check("wr_rvalid", {31'd0, m1_rvalid}, 32'd1);
    step();
    check("wr_hold_addr", mem_addr, 32'h20);
    check("wr_idle_we", {31'd0, mem_we}, 32'd0);

    // timeout
    m0_addr = 32'h30; m0_we = 1'b0; mem_ready = 1'b0; m0_req = 1'b1;
    push(1'b0, 32'd0, 1'b1);
    re_cnt = 0; seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (k == 0) m0_req = 1'b0;
      if (mem_re) re_cnt++;
      if (m0_rvalid) begin
        seen = 1'b1;
        break;
      end
    end
    check("to_seen_rvalid", {31'd0, seen}, 32'd1);
    check("to_re_cycles", re_cnt, 32'd16);
    step();
    m0_addr = 32'h34; mem_ready = 1'b1; mem_rdata = 32'h55; m0_req = 1'b1;
    push(1'b0, 32'h55, 1'b0);
    step();
    check("to_next_gnt", {31'd0, m0_gnt}, 32'd1);
    m0_req = 1'b0;
    step();
    check("to_next_rvalid", {31'd0, m0_rvalid}, 32'd1);
    step();

    // mem_ready on the final allowed cycle completes normally
    m1_addr = 32'h60; m1_we = 1'b0; mem_ready = 1'b0; m1_req = 1'b1;
    push(1'b1, 32'h77, 1'b0);
    step();
    check("edge_gnt", {31'd0, m1_gnt}, 32'd1);
    m1_req = 1'b0;
    repeat (14) step();
    step();
    check("edge_re_last", {31'd0, mem_re}, 32'd1);
    mem_ready = 1'b1; mem_rdata = 32'h77;
    step();
    check("edge_rvalid", {31'd0, m1_rvalid}, 32'd1);
    check("edge_err", {31'd0, m1_err}, 32'd0);
    step();

    // reset in the middle of an access
    mem_ready = 1'b0; m1_req = 1'b1;
    step();
    check("rm_re_before", {31'd0, mem_re}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rm_re_async", {31'd0, mem_re}, 32'd0);
    check("rm_gnt_async", {30'd0, m1_gnt, m0_gnt}, 32'd0);
    m0_req = 1'b1; m0_addr = 32'h44;
    mem_ready = 1'b1; mem_rdata = 32'h99;
    step();
    @(negedge clk) rst = 1'b0;
    push(1'b0, 32'h99, 1'b0);
    step();
    check("rm_tie_m0", {30'd0, m1_gnt, m0_gnt}, 32'd1);
    m0_req = 1'b0; m1_req = 1'b0;
    step();
    check("rm_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd1);
    step();

    // slow memory, requester drops req after its grant
    m0_addr = 32'h70; mem_ready = 1'b0; m0_req = 1'b1;
    push(1'b0, 32'hFF, 1'b0);
    step();
    check("slow_gnt", {31'd0, m0_gnt}, 32'd1);
    m0_req = 1'b0;
    repeat (3) step();
    step();
    check("slow_re5", {31'd0, mem_re}, 32'd1);
    mem_ready = 1'b1; mem_rdata = 32'hFF;
    step();
    check("slow_rvalid", {31'd0, m0_rvalid}, 32'd1);
    check("slow_rdata", m0_rdata, 32'hFF);
    step();
    step();

    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
